// File: rtl/deb_multi_if.sv
// rtl/deb_multi_if.sv - signal bundle between raw discretes, debouncer and interrupt logic
//
// Purpose: groups the per-channel level, strobe and status signals of deb_multi.
// Optional feature macro: DEB_GLITCH_CNT_EN (adds glitch_cnt / glitch_clr).
// Signals:
//   in         raw asynchronous inputs                 (master -> slave)
//   irq_en     per-channel status enable               (master -> slave)
//   irq_clr    per-channel status clear pulse          (master -> slave)
//   out        debounced levels                        (slave -> master)
//   rise/fall  one-cycle edge strobes                  (slave -> master)
//   irq_stat   sticky change status                    (slave -> master)
//   irq        OR of irq_stat                          (slave -> master)
//   glitch_cnt 8 bits per channel, saturating          (slave -> master, macro only)
//   glitch_clr per-channel glitch counter clear        (master -> slave, macro only)
interface deb_multi_if #(
   parameter int unsigned CH = 8
);
   logic [CH-1:0] in;
   logic [CH-1:0] out;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] irq_en;
   logic [CH-1:0] irq_clr;
   logic [CH-1:0] irq_stat;
   logic          irq;
`ifdef DEB_GLITCH_CNT_EN
   logic [8*CH-1:0] glitch_cnt;
   logic [CH-1:0]   glitch_clr;

   modport master (
      output in, irq_en, irq_clr, glitch_clr,
      input  out, rise, fall, irq_stat, irq, glitch_cnt
   );
   modport slave (
      input  in, irq_en, irq_clr, glitch_clr,
      output out, rise, fall, irq_stat, irq, glitch_cnt
   );
`else
   modport master (
      output in, irq_en, irq_clr,
      input  out, rise, fall, irq_stat, irq
   );
   modport slave (
      input  in, irq_en, irq_clr,
      output out, rise, fall, irq_stat, irq
   );
`endif
endinterface

// File: rtl/deb_multi.sv
// rtl/deb_multi.sv - multi-channel debouncer with edge strobes and sticky change status
//
// Purpose: per channel, synchronise a raw discrete, qualify each level change for
// a fixed number of clocks (separate rise / fall times), emit one-cycle strobes and
// keep a sticky, maskable change status that feeds an interrupt line.
// Optional feature macro: DEB_GLITCH_CNT_EN (per-channel saturating glitch counters).
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  deb_multi_if.slave: in, irq_en, irq_clr, out, rise, fall, irq_stat, irq
//        (+ glitch_cnt, glitch_clr with the macro)
// SYNC_STAGES must be at least 2.
module deb_multi #(
   parameter int unsigned     CH          = 8,
   parameter logic [63:0]     FREQ        = 64'd100_000_000,
   parameter logic [63:0]     T_RISE_NS   = 64'd50,
   parameter logic [63:0]     T_FALL_NS   = 64'd50,
   parameter logic [CH-1:0]   RST_V       = {CH{1'b0}},
   parameter int unsigned     SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        rst,
   deb_multi_if.slave bus
);

   localparam logic [63:0] NS_PER_S = 64'd1_000_000_000;
   localparam logic [63:0] N_R_RAW  = (T_RISE_NS * FREQ) / NS_PER_S;
   localparam logic [63:0] N_F_RAW  = (T_FALL_NS * FREQ) / NS_PER_S;
   // A qualification time shorter than one clock still needs one cycle.
   localparam logic [63:0] N_R      = (N_R_RAW == 64'd0) ? 64'd1 : N_R_RAW;
   localparam logic [63:0] N_F      = (N_F_RAW == 64'd0) ? 64'd1 : N_F_RAW;
   localparam logic [63:0] N_MAX    = (N_R > N_F) ? N_R : N_F;
   localparam int unsigned CNT_W    = $clog2(N_MAX + 64'd1);

   localparam logic [CNT_W-1:0] N_R_C   = N_R[CNT_W-1:0];
   localparam logic [CNT_W-1:0] N_F_C   = N_F[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CH-1:0]    sync_q [SYNC_STAGES];
   logic [CH-1:0]    s;
   logic [CNT_W-1:0] cnt_q [CH];
   logic [CNT_W-1:0] cnt_d [CH];
   logic [CNT_W-1:0] cnt_inc;
   logic [CH-1:0]    out_q, out_d;
   logic [CH-1:0]    rise_q, rise_d;
   logic [CH-1:0]    fall_q, fall_d;
   logic [CH-1:0]    stat_q, stat_d;
   logic             irq_q, irq_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      out_d   = out_q;
      rise_d  = '0;
      fall_d  = '0;
      cnt_inc = '0;
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = '0;
         if (s[i] != out_q[i]) begin
            cnt_inc = cnt_q[i] + CNT_ONE;
            // The threshold depends on the direction of the pending change.
            if (cnt_inc == (out_q[i] ? N_F_C : N_R_C)) begin
               out_d[i]  = s[i];
               rise_d[i] = s[i];
               fall_d[i] = ~s[i];
            end else begin
               cnt_d[i] = cnt_inc;
            end
         end
      end
      // Strobes are taken from their next state so status rises with the strobe;
      // a set in the same cycle as a clear wins.
      stat_d = (stat_q & ~bus.irq_clr) | ((rise_d | fall_d) & bus.irq_en);
      irq_d  = |stat_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RST_V;
         end
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
         out_q  <= RST_V;
         rise_q <= '0;
         fall_q <= '0;
         stat_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         sync_q[0] <= bus.in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         stat_q <= stat_d;
         irq_q  <= irq_d;
      end
   end

   assign bus.out      = out_q;
   assign bus.rise     = rise_q;
   assign bus.fall     = fall_q;
   assign bus.irq_stat = stat_q;
   assign bus.irq      = irq_q;

`ifdef DEB_GLITCH_CNT_EN
   logic [7:0] glitch_q [CH];
   logic [7:0] glitch_d [CH];

   // A glitch is a partially qualified change that collapses back to the
   // current level before reaching its threshold.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         glitch_d[i] = glitch_q[i];
         if (bus.glitch_clr[i]) begin
            glitch_d[i] = 8'd0;
         end else if ((s[i] == out_q[i]) && (cnt_q[i] != '0) && (glitch_q[i] != 8'hFF)) begin
            glitch_d[i] = glitch_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            glitch_q[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            glitch_q[i] <= glitch_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         bus.glitch_cnt[8*i +: 8] = glitch_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_deb_multi.sv
// tb/tb_deb_multi.sv - self-checking bench for deb_multi against a history-based reference model
module tb_deb_multi;

   localparam int         CH = 4;
   localparam int         NR = 5;
   localparam int         NF = 10;
   localparam int         SS = 2;
   localparam logic [3:0] RV = 4'b0010;

   logic clk;
   logic rst;
   logic clk_run;
   int   total;
   int   bad;

   deb_multi_if #(.CH(CH)) bus ();

   deb_multi #(
      .CH          (CH),
      .FREQ        (64'd100_000_000),
      .T_RISE_NS   (64'd50),
      .T_FALL_NS   (64'd100),
      .RST_V       (RV),
      .SYNC_STAGES (SS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = clk_run ? ~clk : 1'b0;

   // Reference model: a delay line for the synchroniser and, per channel, the
   // history of synchronised samples. A level change is accepted once the last
   // N samples all disagree with the current output.
   logic [3:0] m_dly [SS];
   bit         hq [CH][$];
   logic [3:0] m_out, m_rise, m_fall, m_stat;
   logic       m_irq;
   int         m_gl [CH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < SS; k++) m_dly[k] = RV;
      for (int c = 0; c < CH; c++) begin
         hq[c].delete();
         m_gl[c] = 0;
      end
      m_out  = RV;
      m_rise = '0;
      m_fall = '0;
      m_stat = '0;
      m_irq  = 1'b0;
   endtask

   task automatic model_edge();
      logic [3:0] s;
      logic [3:0] o;
      bit         prev_diff;
      bit         all_diff;
      int         n;
      int         sz;
      s      = m_dly[SS-1];
      o      = m_out;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
         prev_diff = (hq[c].size() > 0) && (hq[c][hq[c].size()-1] != o[c]);
         hq[c].push_back(s[c]);
         if (hq[c].size() > 16) void'(hq[c].pop_front());
         n  = o[c] ? NF : NR;
         sz = hq[c].size();
         all_diff = (sz >= n);
         for (int k = 0; k < n && k < sz; k++) begin
            if (hq[c][sz-1-k] == o[c]) all_diff = 0;
         end
         if (all_diff) begin
            m_out[c]  = s[c];
            m_rise[c] = s[c];
            m_fall[c] = ~s[c];
         end
`ifdef DEB_GLITCH_CNT_EN
         if (bus.glitch_clr[c]) m_gl[c] = 0;
         else if ((s[c] == o[c]) && prev_diff && (m_gl[c] < 255)) m_gl[c]++;
`endif
      end
      m_stat = (m_stat & ~bus.irq_clr) | ((m_rise | m_fall) & bus.irq_en);
      m_irq  = |m_stat;
      for (int k = SS-1; k > 0; k--) m_dly[k] = m_dly[k-1];
      m_dly[0] = bus.in;
   endtask

   task automatic check_all();
      chk("out", bus.out, m_out);
      chk("rise", bus.rise, m_rise);
      chk("fall", bus.fall, m_fall);
      chk("irq_stat", bus.irq_stat, m_stat);
      chk("irq", bus.irq, m_irq);
`ifdef DEB_GLITCH_CNT_EN
      chk("glitch_cnt", bus.glitch_cnt,
          {m_gl[3][7:0], m_gl[2][7:0], m_gl[1][7:0], m_gl[0][7:0]});
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      clk_run     = 1'b0;
      rst         = 1'b0;
      bus.in      = RV;
      bus.irq_en  = 4'hF;
      bus.irq_clr = 4'h0;
`ifdef DEB_GLITCH_CNT_EN
      bus.glitch_clr = 4'h0;
`endif
      m_reset();

      // Asynchronous reset with no clock running.
      #1 rst = 1'b1;
      #1;
      chk("rst_out", bus.out, 4'b0010);
      chk("rst_rise", bus.rise, 4'h0);
      chk("rst_fall", bus.fall, 4'h0);
      chk("rst_stat", bus.irq_stat, 4'h0);
      chk("rst_irq", bus.irq, 1'b0);

      clk_run = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) step();

      // Clean rise on channel 0: 7 edges from the sampling edge.
      bus.in[0] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         chk("rise_early", bus.out[0], 1'b0);
      end
      step();
      chk("rise_out", bus.out[0], 1'b1);
      chk("rise_strobe", bus.rise[0], 1'b1);
      chk("rise_stat", bus.irq_stat[0], 1'b1);
      chk("rise_irq", bus.irq, 1'b1);
      step();
      chk("rise_one_cycle", bus.rise[0], 1'b0);

      // Fall on channel 1 (reset-high): 12 edges.
      bus.in[1] = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         step();
         chk("fall_early", bus.out[1], 1'b1);
      end
      step();
      chk("fall_out", bus.out[1], 1'b0);
      chk("fall_only", bus.fall, 4'b0010);
      chk("fall_no_rise", bus.rise, 4'h0);

      // Glitch rejection on channel 2.
      for (int g = 0; g < 300; g++) begin
         bus.in[2] = 1'b1;
         repeat (4) step();
         bus.in[2] = 1'b0;
         repeat (6) step();
         if (g == 0) begin
            chk("glitch_out", bus.out[2], 1'b0);
            chk("glitch_nostrobe", bus.rise, 4'h0);
`ifdef DEB_GLITCH_CNT_EN
            chk("glitch_one", bus.glitch_cnt[23:16], 8'd1);
`else
            break;
`endif
         end
      end
`ifdef DEB_GLITCH_CNT_EN
      chk("glitch_sat", bus.glitch_cnt[23:16], 8'd255);
      bus.glitch_clr[2] = 1'b1;
      step();
      bus.glitch_clr[2] = 1'b0;
      chk("glitch_clr", bus.glitch_cnt[23:16], 8'd0);
`endif

      // Set/clear collision on a channel 0 rise.
      bus.in[0] = 1'b0;
      repeat (14) step();
      bus.irq_clr = 4'hF;
      step();
      bus.irq_clr = 4'h0;
      chk("clr_all", bus.irq_stat, 4'h0);
      bus.in[0] = 1'b1;
      repeat (6) step();
      bus.irq_clr[0] = 1'b1;
      step();
      bus.irq_clr[0] = 1'b0;
      chk("coll_rise", bus.rise[0], 1'b1);
      chk("coll_stat", bus.irq_stat[0], 1'b1);
      bus.irq_clr[0] = 1'b1;
      step();
      bus.irq_clr[0] = 1'b0;
      chk("clr_stat", bus.irq_stat[0], 1'b0);
      chk("clr_irq", bus.irq, 1'b0);

      // Reset in the middle of a channel 3 rise qualification.
      bus.in[3] = 1'b1;
      repeat (5) step();
      rst = 1'b1;
      m_reset();
      #1;
      chk("midrst_out", bus.out[3], 1'b0);
      check_all();
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         step();
         chk("midrst_early", bus.out[3], 1'b0);
      end
      step();
      chk("midrst_out7", bus.out[3], 1'b1);

      // Randomised traffic on all channels.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int rate;
         rate = (cyc / 500) % 3;
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, (rate == 0) ? 3 : (rate == 1) ? 9 : 20) == 0)
               bus.in[c] = ~bus.in[c];
         end
         if ($urandom_range(0, 31) == 0) bus.irq_en = 4'($urandom);
         bus.irq_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
`ifdef DEB_GLITCH_CNT_EN
         bus.glitch_clr = ($urandom_range(0, 63) == 0) ? 4'($urandom) : 4'h0;
`endif
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            m_reset();
            #1;
            check_all();
            rst = 1'b0;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
